// File: rtl/scc_pkg.sv
// Shared constants, types and input scaling for the SCC output stage.
// Used by scc_output_stage and scc_delta_sigma.
package scc_pkg;

    localparam int unsigned InWidth    = 11;
    localparam int unsigned ActWidth   = 3;
    localparam int unsigned InOffset   = 640;
    localparam int unsigned ScaleShift = 5;
    localparam int unsigned FiltShift  = 3;
    localparam int unsigned FiltWidth  = 19;
    localparam int unsigned PcmWidth   = 16;

    localparam logic [ActWidth-1:0] SampleSlot = 3'd2;
    // Flips the sign bit so the modulator sees an offset-binary level.
    localparam logic [PcmWidth-1:0] DsBias     = 16'h8000;

    typedef logic signed [PcmWidth-1:0]  pcm_t;
    typedef logic signed [FiltWidth-1:0] filt_t;

    // Converts a raw mixer sum into a signed sample scaled up to full pcm range.
    function automatic pcm_t scale_input(input logic [InWidth-1:0] raw, input logic offset);
        pcm_t x;
        if (offset) begin
            x = pcm_t'({{(PcmWidth-InWidth){1'b0}}, raw}) - pcm_t'(InOffset);
        end else begin
            x = pcm_t'({{(PcmWidth-InWidth){raw[InWidth-1]}}, raw});
        end
        return x <<< ScaleShift;
    endfunction

endpackage

// File: rtl/scc_delta_sigma.sv
// First-order delta-sigma modulator turning a signed pcm sample into a 1-bit stream.
module scc_delta_sigma
    import scc_pkg::*;
(
    input  logic                clk,
    input  logic                nreset,
    input  logic [PcmWidth-1:0] pcm_data,
    output logic                dac_out
);

    logic [PcmWidth-1:0] acc_q, acc_d;
    logic                dac_q, dac_d;
    logic [PcmWidth:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, pcm_data ^ DsBias};
        acc_d = sum[PcmWidth-1:0];
        dac_d = sum[PcmWidth];
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            acc_q <= '0;
            dac_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            dac_q <= dac_d;
        end
    end

    assign dac_out = dac_q;

endmodule

// File: rtl/scc_output_stage.sv
// SCC mixer output stage: sample strobe, scaling, optional low-pass (SCC_OUTPUT_LPF_EN),
// valid/ready output register with sticky overrun, and delta-sigma DAC bitstream.
module scc_output_stage
    import scc_pkg::*;
#(
    parameter int unsigned add_offset = 1
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [ActWidth-1:0] active,
    input  logic [InWidth-1:0]  left_in,
    output logic [PcmWidth-1:0] pcm_data,
    output logic                pcm_valid,
    input  logic                pcm_ready,
    output logic                pcm_overrun,
    output logic                dac_out
);

    logic hist_q, hist_d;
    logic strobe;
    logic strobe_q, strobe_d;
    pcm_t x16_q, x16_d;
    pcm_t y;

    logic [PcmWidth-1:0] pcm_q, pcm_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    // One strobe per entry into the sample slot, however long active stalls there.
    always_comb begin
        strobe   = (active == SampleSlot) && !hist_q;
        hist_d   = (active == SampleSlot);
        strobe_d = strobe;
        x16_d    = strobe ? scale_input(left_in, add_offset != 0) : x16_q;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            hist_q   <= 1'b0;
            strobe_q <= 1'b0;
            x16_q    <= '0;
        end else begin
            hist_q   <= hist_d;
            strobe_q <= strobe_d;
            x16_q    <= x16_d;
        end
    end

`ifdef SCC_OUTPUT_LPF_EN
    filt_t s_q, s_d;
    filt_t s_next;

    always_comb begin
        s_next = s_q + filt_t'(x16_q) - (s_q >>> FiltShift);
        s_d    = strobe_q ? s_next : s_q;
        // s_next >>> FiltShift leaves exactly PcmWidth significant bits.
        y      = pcm_t'(s_next[FiltShift +: PcmWidth]);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end
`else
    always_comb begin
        y = x16_q;
    end
`endif

    always_comb begin
        pcm_d     = pcm_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (strobe_q) begin
            pcm_d   = y;
            valid_d = 1'b1;
            if (valid_q && !pcm_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && pcm_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            pcm_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pcm_q     <= pcm_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign pcm_data    = pcm_q;
    assign pcm_valid   = valid_q;
    assign pcm_overrun = overrun_q;

    scc_delta_sigma u_delta_sigma (
        .clk      (clk),
        .nreset   (nreset),
        .pcm_data (pcm_q),
        .dac_out  (dac_out)
    );

endmodule

// File: tb/tb_scc_output_stage.sv
// Directed self-checking bench for scc_output_stage (default build and SCC_OUTPUT_LPF_EN).
module tb_scc_output_stage;

    logic        clk = 1'b0;
    logic        nreset;
    logic [2:0]  active;
    logic [10:0] left_in;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        pcm_overrun;
    logic        dac_out;

    int checks = 0;
    int errors = 0;

`ifdef SCC_OUTPUT_LPF_EN
    localparam logic [15:0] ExpFirst  = 16'd2540;
    localparam logic [15:0] ExpB1     = 16'd4762;
    localparam logic [15:0] ExpB2     = 16'd6707;
    localparam logic [15:0] ExpOvr2   = 16'd2478;
    localparam logic [15:0] ExpFresh  = 16'd256;
`else
    localparam logic [15:0] ExpFirst  = 16'd20320;
    localparam logic [15:0] ExpB1     = 16'd20320;
    localparam logic [15:0] ExpB2     = 16'd20320;
    localparam logic [15:0] ExpOvr2   = 16'd2048;
    localparam logic [15:0] ExpFresh  = 16'd2048;
`endif

    scc_output_stage #(.add_offset(1)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .active      (active),
        .left_in     (left_in),
        .pcm_data    (pcm_data),
        .pcm_valid   (pcm_valid),
        .pcm_ready   (pcm_ready),
        .pcm_overrun (pcm_overrun),
        .dac_out     (dac_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        nreset = 1'b0;
        active = 3'd0;
        tick();
        nreset = 1'b1;
    endtask

    // One full slot rotation; load lands on the edge after active==3 begins.
    task automatic period(output logic [15:0] pcm_ld, output logic v_ld, output logic v_after);
        for (int a = 0; a < 6; a++) begin
            active = 3'(a);
            tick();
            if (a == 3) begin
                pcm_ld = pcm_data;
                v_ld   = pcm_valid;
            end
            if (a == 4) v_after = pcm_valid;
        end
    endtask

    initial begin
        logic [15:0] p;
        logic        vl, va;
        logic [15:0] exp_b [3];
        int          loads;
        int          ones;
        int          diff;

        exp_b[0] = ExpFirst;
        exp_b[1] = ExpB1;
        exp_b[2] = ExpB2;

        // Reset with random inputs
        nreset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            active    = 3'($urandom_range(0, 5));
            left_in   = 11'($urandom);
            pcm_ready = 1'($urandom);
            tick();
        end
        check("rst_pcm", 32'(pcm_data), 32'd0);
        check("rst_valid", 32'(pcm_valid), 32'd0);
        check("rst_overrun", 32'(pcm_overrun), 32'd0);
        check("rst_dac", 32'(dac_out), 32'd0);

        // Steady stream at left_in=1275
        apply_reset();
        pcm_ready = 1'b1;
        left_in   = 11'd1275;
        for (int i = 0; i < 35; i++) begin
            period(p, vl, va);
            if (i < 3) begin
                check($sformatf("stream_pcm%0d", i), 32'(p), 32'(exp_b[i]));
                check($sformatf("stream_vld%0d", i), 32'(vl), 32'd1);
                check($sformatf("stream_vclr%0d", i), 32'(va), 32'd0);
            end
            if (i == 34) begin
                diff = int'(p) - 20320;
                if (diff < 0) diff = -diff;
                checks++;
                assert (diff <= 203) else begin
                    errors++;
                    $error("FAIL settle observed=%0d expected=20320+-203", p);
                end
            end
        end

        // Overrun with consumer stalled across two strobes
        apply_reset();
        pcm_ready = 1'b0;
        left_in   = 11'd1275;
        period(p, vl, va);
        check("ovr_first", 32'(p), 32'(ExpFirst));
        check("ovr_clear", 32'(pcm_overrun), 32'd0);
        left_in = 11'd704;
        period(p, vl, va);
        check("ovr_second", 32'(p), 32'(ExpOvr2));
        check("ovr_set", 32'(pcm_overrun), 32'd1);
        check("ovr_valid", 32'(pcm_valid), 32'd1);
        pcm_ready = 1'b1;
        active    = 3'd0;
        tick();
        check("ovr_consumed", 32'(pcm_valid), 32'd0);
        check("ovr_sticky", 32'(pcm_overrun), 32'd1);

        // Stall at slot 2 yields one load
        apply_reset();
        left_in = 11'd1275;
        active  = 3'd0;
        tick();
        active = 3'd1;
        tick();
        active = 3'd2;
        loads  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pcm_valid) loads++;
            if (i == 0) left_in = 11'd704;
        end
        active = 3'd3;
        tick();
        if (pcm_valid) loads++;
        active = 3'd4;
        tick();
        if (pcm_valid) loads++;
        check("stall_loads", 32'(loads), 32'd1);
        check("stall_pcm", 32'(pcm_data), 32'(ExpFirst));

        // Reset pulse with a sample in flight
        active = 3'd5;
        tick();
        active = 3'd0;
        tick();
        active = 3'd1;
        tick();
        active = 3'd2;
        tick();
        nreset = 1'b0;
        active = 3'd3;
        tick();
        check("midrst_pcm", 32'(pcm_data), 32'd0);
        check("midrst_valid", 32'(pcm_valid), 32'd0);
        nreset = 1'b1;
        active = 3'd2;
        tick();
        check("midrst_discard", 32'(pcm_data), 32'd0);
        active = 3'd3;
        tick();
        check("midrst_reload", 32'(pcm_data), 32'(ExpFresh));
        check("midrst_reload_vld", 32'(pcm_valid), 32'd1);

        // Delta-sigma at pcm_data=0 alternates
        apply_reset();
        active = 3'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ds_alt%0d", i), 32'(dac_out), 32'(i % 2));
        end

`ifndef SCC_OUTPUT_LPF_EN
        // Delta-sigma density at pcm_data=0x4000
        left_in = 11'd1152;
        period(p, vl, va);
        check("ds_level", 32'(p), 32'h4000);
        active = 3'd0;
        tick();
        ones = 0;
        for (int i = 0; i < 65536; i++) begin
            tick();
            if (dac_out) ones++;
        end
        check("ds_density", 32'(ones), 32'd49152);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
